alu_cnt_dec_unit: RTL and testbench



---
 rtl/alu_cnt_dec_unit_pkg.sv | 19 +
 rtl/alu_cnt_dec_unit_alu4_core.sv | 53 +++++
 rtl/alu_cnt_dec_unit.sv | 58 +++++
 tb/tb_alu_cnt_dec_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/alu_cnt_dec_unit_pkg.sv
// rtl/alu_cnt_dec_unit_pkg.sv - shared opcodes, widths and helpers for the ALU/decoder/counter unit
package alu_cnt_dec_unit_pkg;

  localparam int CNT_W = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  function automatic logic [7:0] onehot8(input logic [2:0] sel);
    return 8'b1 << sel;
  endfunction

endpackage

// File: rtl/alu_cnt_dec_unit_alu4_core.sv
// rtl/alu_cnt_dec_unit_alu4_core.sv - combinational 4-bit ALU with zero/overflow/carry flags
module alu4_core
  import alu_cnt_dec_unit_pkg::*;
(
  input  logic [2:0] fnselec_i,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [3:0] res_o,
  output logic       zero_o,
  output logic       overflow_o,
  output logic       carry_o
);

  logic [4:0] sum5;
  logic [4:0] sub5;
  logic       ovf_add;
  logic       ovf_sub;

  // Subtraction is A + ~B + 1, so sub5[4] is the "no borrow" carry.
  assign sum5    = {1'b0, a_i} + {1'b0, b_i};
  assign sub5    = {1'b0, a_i} + {1'b0, ~b_i} + 5'd1;
  assign ovf_add = (a_i[3] == b_i[3]) && (sum5[3] != a_i[3]);
  assign ovf_sub = (a_i[3] != b_i[3]) && (sub5[3] != a_i[3]);

  always_comb begin
    res_o      = 4'b0;
    carry_o    = 1'b0;
    overflow_o = 1'b0;
    case (fnselec_i)
      OP_ADD: begin
        res_o      = sum5[3:0];
        carry_o    = sum5[4];
        overflow_o = ovf_add;
      end
      OP_SUB: begin
        res_o      = sub5[3:0];
        carry_o    = sub5[4];
        overflow_o = ovf_sub;
      end
      OP_NOT:  res_o = ~a_i;
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      // Sign of the true difference is the result sign corrected by overflow.
      OP_SLT:  res_o = {3'b0, sub5[3] ^ ovf_sub};
      OP_EQ:   res_o = {3'b0, a_i == b_i};
      default: res_o = 4'b0;
    endcase
  end

  assign zero_o = (res_o == 4'b0);

endmodule

// File: rtl/alu_cnt_dec_unit.sv
// rtl/alu_cnt_dec_unit.sv - top: ALU, 3-to-8 decoder and 3-bit enabled down-counter
module alu_cnt_dec_unit
  import alu_cnt_dec_unit_pkg::*;
#(
  parameter logic [CNT_W-1:0] COUNT_INIT = 3'd7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       alu_fnselec,
  input  logic [3:0]       alu_a,
  input  logic [3:0]       alu_b,
  output logic [3:0]       alu_res,
  output logic             alu_zero,
  output logic             alu_overflow,
  output logic             alu_carry,
  input  logic [2:0]       x,
  input  logic             en,
  output logic [7:0]       y_dec,
  input  logic             counter_en,
  output logic [CNT_W-1:0] dec_counter_out
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  alu4_core u_alu (
    .fnselec_i  (alu_fnselec),
    .a_i        (alu_a),
    .b_i        (alu_b),
    .res_o      (alu_res),
    .zero_o     (alu_zero),
    .overflow_o (alu_overflow),
    .carry_o    (alu_carry)
  );

  assign y_dec = en ? onehot8(x) : 8'h00;

  // Reaching zero reloads COUNT_INIT, which equals the natural wrap for the default.
  always_comb begin
    cnt_d = cnt_q;
    if (counter_en) begin
      cnt_d = (cnt_q == '0) ? COUNT_INIT : cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= COUNT_INIT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign dec_counter_out = cnt_q;

endmodule

// File: tb/tb_alu_cnt_dec_unit.sv
// tb/tb_alu_cnt_dec_unit.sv - self-checking bench for alu_cnt_dec_unit
module tb_alu_cnt_dec_unit;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic       zero;
    logic       ovf;
    logic       carry;
  } alu_vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] alu_fnselec;
  logic [3:0] alu_a, alu_b, alu_res;
  logic       alu_zero, alu_overflow, alu_carry;
  logic [2:0] x;
  logic       en;
  logic [7:0] y_dec;
  logic       counter_en;
  logic [2:0] dec_counter_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_cnt_dec_unit #(.COUNT_INIT(3'd7)) dut (
    .clk             (clk),
    .rst             (rst),
    .alu_fnselec     (alu_fnselec),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .alu_res         (alu_res),
    .alu_zero        (alu_zero),
    .alu_overflow    (alu_overflow),
    .alu_carry       (alu_carry),
    .x               (x),
    .en              (en),
    .y_dec           (y_dec),
    .counter_en      (counter_en),
    .dec_counter_out (dec_counter_out)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic alu_vec_t mk(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                                  input logic [3:0] res, input logic z, input logic o, input logic c);
    alu_vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.zero = z; v.ovf = o; v.carry = c;
    return v;
  endfunction

  // Reference ALU from integer arithmetic on unsigned and signed interpretations.
  function automatic alu_vec_t ref_alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    alu_vec_t v;
    int ua, ub, sa, sb, s;
    ua = int'(a); ub = int'(b);
    sa = (ua > 7) ? ua - 16 : ua;
    sb = (ub > 7) ? ub - 16 : ub;
    v.op = op; v.a = a; v.b = b; v.ovf = 1'b0; v.carry = 1'b0;
    case (op)
      3'd0: begin
        v.res = 4'((ua + ub) % 16); v.carry = (ua + ub) > 15;
        s = sa + sb; v.ovf = (s > 7) || (s < -8);
      end
      3'd1: begin
        v.res = 4'((ua - ub + 16) % 16); v.carry = (ua >= ub);
        s = sa - sb; v.ovf = (s > 7) || (s < -8);
      end
      3'd2: v.res = 4'(15 - ua);
      3'd3: v.res = a & b;
      3'd4: v.res = a | b;
      3'd5: v.res = a ^ b;
      3'd6: v.res = (sa < sb) ? 4'd1 : 4'd0;
      default: v.res = (ua == ub) ? 4'd1 : 4'd0;
    endcase
    v.zero = (v.res == 4'd0);
    return v;
  endfunction

  task automatic apply_alu(input alu_vec_t v, input string tag);
    alu_fnselec = v.op; alu_a = v.a; alu_b = v.b;
    #1;
    check({tag, ".res"},   int'(alu_res),      int'(v.res));
    check({tag, ".zero"},  int'(alu_zero),     int'(v.zero));
    check({tag, ".ovf"},   int'(alu_overflow), int'(v.ovf));
    check({tag, ".carry"}, int'(alu_carry),    int'(v.carry));
  endtask

  initial begin
    alu_vec_t vecs[$];
    int exp_seq[9] = '{6, 5, 4, 3, 2, 1, 0, 7, 6};
    int model;

    vecs.push_back(mk(3'd0, 4'b0111, 4'b0001, 4'b1000, 0, 1, 0));
    vecs.push_back(mk(3'd0, 4'b1111, 4'b0001, 4'b0000, 1, 0, 1));
    vecs.push_back(mk(3'd1, 4'b0011, 4'b0001, 4'b0010, 0, 0, 1));
    vecs.push_back(mk(3'd1, 4'b1000, 4'b0001, 4'b0111, 0, 1, 1));
    vecs.push_back(mk(3'd6, 4'b1111, 4'b0001, 4'b0001, 0, 0, 0));
    vecs.push_back(mk(3'd6, 4'b0001, 4'b1111, 4'b0000, 1, 0, 0));
    vecs.push_back(mk(3'd3, 4'b1100, 4'b1010, 4'b1000, 0, 0, 0));
    vecs.push_back(mk(3'd4, 4'b1100, 4'b1010, 4'b1110, 0, 0, 0));
    vecs.push_back(mk(3'd5, 4'b1100, 4'b1010, 4'b0110, 0, 0, 0));
    vecs.push_back(mk(3'd2, 4'b1100, 4'b1010, 4'b0011, 0, 0, 0));
    vecs.push_back(mk(3'd7, 4'b0101, 4'b0101, 4'b0001, 0, 0, 0));
    vecs.push_back(mk(3'd7, 4'b0101, 4'b0100, 4'b0000, 1, 0, 0));

    rst = 1'b1; counter_en = 1'b0; en = 1'b0; x = 3'd0;
    alu_fnselec = 3'd0; alu_a = 4'd0; alu_b = 4'd0;
    tick();
    check("reset_cnt", int'(dec_counter_out), 7);
    rst = 1'b0;

    foreach (vecs[i]) apply_alu(vecs[i], $sformatf("alu_vec%0d", i));

    for (int i = 0; i < 300; i++) begin
      alu_vec_t r;
      r = ref_alu(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
      apply_alu(r, $sformatf("alu_rand%0d", i));
    end

    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      x = 3'(i);
      #1;
      check($sformatf("dec_x%0d", i), int'(y_dec), 1 << i);
    end
    en = 1'b0; x = 3'd5;
    #1;
    check("dec_dis", int'(y_dec), 0);

    counter_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("cnt_step%0d", i), int'(dec_counter_out), exp_seq[i]);
    end
    counter_en = 1'b0;
    tick(); tick();
    check("cnt_hold", int'(dec_counter_out), 6);
    counter_en = 1'b1; #2; counter_en = 1'b0;
    tick();
    check("cnt_en_between_edges", int'(dec_counter_out), 6);
    rst = 1'b1; counter_en = 1'b1;
    tick();
    check("cnt_rst_priority", int'(dec_counter_out), 7);
    rst = 1'b0;
    tick();
    check("cnt_resume", int'(dec_counter_out), 6);

    // Reset pulses must leave the combinational paths untouched.
    alu_fnselec = 3'd0; alu_a = 4'b0010; alu_b = 4'b0011; x = 3'd2; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rst = (i % 2 == 0);
      #1;
      check($sformatf("iso_res_pre%0d", i), int'(alu_res), 5);
      check($sformatf("iso_dec_pre%0d", i), int'(y_dec), 8'h04);
      tick();
      check($sformatf("iso_res_post%0d", i), int'(alu_res), 5);
      check($sformatf("iso_dec_post%0d", i), int'(y_dec), 8'h04);
    end
    rst = 1'b0;

    model = 7;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 200; i++) begin
      rst = ($urandom_range(0, 7) == 0);
      counter_en = 1'($urandom);
      if (rst) model = 7;
      else if (counter_en) model = (model + 7) % 8;
      tick();
      check($sformatf("cnt_rand%0d", i), int'(dec_counter_out), model);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
